// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit_pkg
// Description : Shared op-codes, widths and payload types for alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_unit_pkg;

    localparam int DATA_W        = 32;
    localparam int TAG_W_DEFAULT = 4;
    localparam int OVF_CNT_W     = 8;

    localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_NOR = 3'b100,
        OP_XOR = 3'b101,
        OP_SUB = 3'b110
    } alu_op_e;

    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              unsig;
    } alu_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              compout;
        logic              overflow;
        logic              illegal;
    } alu_rsp_t;

    // 3'b011 and 3'b111 are the only unassigned encodings.
    function automatic logic op_is_legal(input logic [2:0] op);
        return !(op[1] && op[0]);
    endfunction

endpackage : alu_exec_unit_pkg
`default_nettype wire

// File: rtl/alu_exec_unit_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational ALU datapath: result, compare, overflow, illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_exec_unit_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_unsig,
    output logic [DATA_W-1:0] o_result,
    output logic              o_compout,
    output logic              o_overflow,
    output logic              o_illegal
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_lt_s;
    logic              w_lt_u;
    logic              w_sa;
    logic              w_sb;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = i_a - i_b;
    assign w_lt_s = $signed(i_a) < $signed(i_b);
    assign w_lt_u = i_a < i_b;
    assign w_sa   = i_a[DATA_W-1];
    assign w_sb   = i_b[DATA_W-1];

    always_comb begin
        o_result   = '0;
        o_compout  = 1'b0;
        o_overflow = 1'b0;
        o_illegal  = 1'b0;

        if (op_is_legal(i_op)) begin
            o_compout = i_unsig ? w_lt_u : w_lt_s;
        end else begin
            o_illegal = 1'b1;
        end

        case (i_op)
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_NOR: o_result = ~(i_a | i_b);
            OP_XOR: o_result = i_a ^ i_b;
            OP_ADD: begin
                o_result   = w_sum[DATA_W-1:0];
                o_overflow = i_unsig ? w_sum[DATA_W]
                                     : ((w_sa == w_sb) && (w_sum[DATA_W-1] != w_sa));
            end
            // Unsigned subtract overflows exactly when it borrows.
            OP_SUB: begin
                o_result   = w_diff;
                o_overflow = i_unsig ? w_lt_u
                                     : ((w_sa != w_sb) && (w_diff[DATA_W-1] != w_sa));
            end
            default: ;
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Two-stage valid/ready ALU pipeline with overflow statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [DATA_W-1:0]    req_a,
    input  logic [DATA_W-1:0]    req_b,
    input  logic                 req_unsig,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_result,
    output logic                 rsp_compout,
    output logic                 rsp_overflow,
    output logic                 rsp_illegal,
    output logic [TAG_W-1:0]     rsp_tag,
    input  logic                 clr_sticky,
    output logic                 ovf_sticky,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    logic                 r_s1_valid;
    alu_req_t             r_s1_req;
    logic [TAG_W-1:0]     r_s1_tag;

    logic                 r_s2_valid;
    alu_rsp_t             r_s2_rsp;
    logic [TAG_W-1:0]     r_s2_tag;

    logic                 r_ovf_sticky;
    logic [OVF_CNT_W-1:0] r_ovf_count;

    logic                 w_s1_free;
    logic                 w_s2_free;
    logic                 w_handoff;
    alu_rsp_t             w_alu_rsp;

    assign w_s2_free = !r_s2_valid || rsp_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;
    assign w_handoff = r_s2_valid && rsp_ready;
    assign req_ready = w_s1_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_req   <= '0;
            r_s1_tag   <= '0;
        end else if (w_s1_free) begin
            r_s1_valid <= req_valid;
            if (req_valid) begin
                r_s1_req.op    <= req_op;
                r_s1_req.a     <= req_a;
                r_s1_req.b     <= req_b;
                r_s1_req.unsig <= req_unsig;
                r_s1_tag       <= req_tag;
            end
        end
    end

    alu_core u_alu_core (
        .i_op       (r_s1_req.op),
        .i_a        (r_s1_req.a),
        .i_b        (r_s1_req.b),
        .i_unsig    (r_s1_req.unsig),
        .o_result   (w_alu_rsp.result),
        .o_compout  (w_alu_rsp.compout),
        .o_overflow (w_alu_rsp.overflow),
        .o_illegal  (w_alu_rsp.illegal)
    );

    // S2 only loads when its current response has left, so rsp_* hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_rsp   <= '0;
            r_s2_tag   <= '0;
        end else if (w_s2_free) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_rsp <= w_alu_rsp;
                r_s2_tag <= r_s1_tag;
            end
        end
    end

    // A clear in the same cycle as a counted handoff takes priority.
    always_ff @(posedge clk) begin
        if (rst || clr_sticky) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_count  <= '0;
        end else if (w_handoff && r_s2_rsp.overflow) begin
            r_ovf_sticky <= 1'b1;
            if (r_ovf_count != OVF_CNT_MAX) begin
                r_ovf_count <= r_ovf_count + 1'b1;
            end
        end
    end

    assign rsp_valid    = r_s2_valid;
    assign rsp_result   = r_s2_rsp.result;
    assign rsp_compout  = r_s2_rsp.compout;
    assign rsp_overflow = r_s2_rsp.overflow;
    assign rsp_illegal  = r_s2_rsp.illegal;
    assign rsp_tag      = r_s2_tag;
    assign ovf_sticky   = r_ovf_sticky;
    assign ovf_count    = r_ovf_count;

endmodule : alu_exec_unit
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam int TAG_W = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint UMAX = 64'sd4294967295;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic             req_unsig;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic             rsp_compout;
    logic             rsp_overflow;
    logic             rsp_illegal;
    logic [TAG_W-1:0] rsp_tag;
    logic             clr_sticky;
    logic             ovf_sticky;
    logic [7:0]       ovf_count;

    alu_exec_unit #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_unsig    (req_unsig),
        .req_tag      (req_tag),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_compout  (rsp_compout),
        .rsp_overflow (rsp_overflow),
        .rsp_illegal  (rsp_illegal),
        .rsp_tag      (rsp_tag),
        .clr_sticky   (clr_sticky),
        .ovf_sticky   (ovf_sticky),
        .ovf_count    (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic             cmp;
        logic             ovf;
        logic             ill;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t             q[$];
    int               tag_log[$];
    int               n_assert = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    logic             m_sticky = 1'b0;
    int               m_count  = 0;
    logic             last_req_fire;
    logic [31:0]      last_res;
    logic             last_cmp;
    logic             last_ovf;
    logic             last_ill;
    logic [TAG_W-1:0] last_tag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic u,
                                   input logic [TAG_W-1:0] tag, input int acc);
        exp_t   e;
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        e.tag = tag;
        e.acc = acc;
        e.ill = 1'b0;
        e.ovf = 1'b0;
        e.cmp = u ? (ua < ub) : (sa < sb);
        r = 0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b100: e.res = ~(a | b);
            3'b101: e.res = a ^ b;
            3'b010: begin
                r = u ? ua + ub : sa + sb;
                e.res = r[31:0];
                e.ovf = u ? (r > UMAX) : (r > SMAX || r < SMIN);
            end
            3'b110: begin
                r = u ? ua - ub : sa - sb;
                e.res = r[31:0];
                e.ovf = u ? (r < 0) : (r > SMAX || r < SMIN);
            end
            default: begin
                e.res = 32'h0;
                e.cmp = 1'b0;
                e.ill = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic step();
        logic             rf, qf, e_rv, clr;
        logic [2:0]       op;
        logic [31:0]      a, b;
        logic             u;
        logic [TAG_W-1:0] t;
        exp_t             h;
        #1;
        if (!rst) begin
            chk("req_ready", 64'(req_ready), 64'(!(q.size() == 2 && !rsp_ready)));
            e_rv = 1'b0;
            if (q.size() > 0) e_rv = (cyc > q[0].acc);
            chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
            if (rsp_valid && q.size() > 0)
                chk("rsp_data", 64'({rsp_result, rsp_compout, rsp_overflow, rsp_illegal, rsp_tag}),
                    64'({q[0].res, q[0].cmp, q[0].ovf, q[0].ill, q[0].tag}));
        end
        rf  = req_valid && req_ready;
        qf  = rsp_valid && rsp_ready;
        clr = clr_sticky;
        op = req_op; a = req_a; b = req_b; u = req_unsig; t = req_tag;
        if (qf) begin
            last_res = rsp_result; last_cmp = rsp_compout; last_ovf = rsp_overflow;
            last_ill = rsp_illegal; last_tag = rsp_tag;
        end
        @(posedge clk);
        cyc++;
        last_req_fire = 1'b0;
        if (rst) begin
            q.delete();
            m_sticky = 1'b0;
            m_count  = 0;
        end else begin
            h.ovf = 1'b0;
            if (qf && q.size() > 0) begin
                h = q.pop_front();
                tag_log.push_back(int'(last_tag));
            end
            if (clr) begin
                m_sticky = 1'b0;
                m_count  = 0;
            end else if (qf && h.ovf) begin
                m_sticky = 1'b1;
                if (m_count < 255) m_count++;
            end
            if (rf) begin
                q.push_back(model(op, a, b, u, t, cyc));
                last_req_fire = 1'b1;
            end
        end
        #1;
        chk("ovf_count", 64'(ovf_count), 64'(m_count));
        chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
    endtask

    task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic u, input logic [TAG_W-1:0] t);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_unsig = u; req_tag = t;
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic u, input logic [TAG_W-1:0] t);
        set_req(op, a, b, u, t);
        for (int i = 0; i < 50; i++) begin
            step();
            if (last_req_fire) break;
        end
        chk("send_accept", 64'(last_req_fire), 64'(1));
        req_valid = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) step();
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_a = '0; req_b = '0;
        req_unsig = 1'b0; req_tag = '0; rsp_ready = 1'b1; clr_sticky = 1'b0;
        step();
        step();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_bundle", 64'({rsp_result, rsp_compout, rsp_overflow, rsp_illegal, rsp_tag}), 64'(0));
        rst = 1'b0;
        step();
        chk("post_rst_ready", 64'(req_ready), 64'(1));

        // Signed add overflow, then unsigned add wrap and signed subtract.
        send(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd1);
        chk("lat_s1_only", 64'(rsp_valid), 64'(0));
        step();
        chk("lat_s2_valid", 64'(rsp_valid), 64'(1));
        drain();
        chk("sadd_res", 64'(last_res), 64'(32'h8000_0000));
        chk("sadd_ovf", 64'(last_ovf), 64'(1));
        chk("sadd_cmp", 64'(last_cmp), 64'(0));
        chk("sadd_cnt", 64'(ovf_count), 64'(1));

        send(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 4'd2);
        drain();
        chk("uadd_res", 64'(last_res), 64'(32'h0));
        chk("uadd_ovf", 64'(last_ovf), 64'(1));
        send(3'b110, 32'd5, 32'd7, 1'b0, 4'd3);
        drain();
        chk("ssub_res", 64'(last_res), 64'(32'hFFFF_FFFE));
        chk("ssub_cmp", 64'(last_cmp), 64'(1));
        chk("ssub_ovf", 64'(last_ovf), 64'(0));

        send(3'b011, 32'h1234_5678, 32'h0000_0001, 1'b0, 4'd5);
        drain();
        chk("ill_res", 64'(last_res), 64'(0));
        chk("ill_flag", 64'(last_ill), 64'(1));
        chk("ill_ovf", 64'(last_ovf), 64'(0));
        chk("ill_tag", 64'(last_tag), 64'(5));

        // Back-pressure: third request must be refused while output stalls.
        tag_log.delete();
        rsp_ready = 1'b0;
        set_req(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 4'd1);
        step();
        chk("stall_acc1", 64'(last_req_fire), 64'(1));
        set_req(3'b101, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, 4'd2);
        step();
        chk("stall_acc2", 64'(last_req_fire), 64'(1));
        set_req(3'b100, 32'h0000_00FF, 32'h00FF_0000, 1'b0, 4'd3);
        for (int i = 0; i < 4; i++) step();
        chk("stall_acc3", 64'(last_req_fire), 64'(0));
        chk("stall_ready", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_req_fire) break;
        end
        chk("stall_acc3_late", 64'(last_req_fire), 64'(1));
        drain();
        chk("order_n", 64'(tag_log.size()), 64'(3));
        if (tag_log.size() == 3) begin
            chk("order_0", 64'(tag_log[0]), 64'(1));
            chk("order_1", 64'(tag_log[1]), 64'(2));
            chk("order_2", 64'(tag_log[2]), 64'(3));
        end

        // Reset while two requests are in flight.
        set_req(3'b010, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 4'd6);
        step();
        set_req(3'b010, 32'h8000_0000, 32'h8000_0000, 1'b0, 4'd7);
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("flush_ready", 64'(req_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_no_rsp", 64'(rsp_valid), 64'(0));
        end
        chk("flush_cnt", 64'(ovf_count), 64'(0));

        // Saturation, then clear racing an overflow handoff.
        for (int i = 0; i < 256; i++) send(3'b010, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'(i));
        drain();
        chk("sat_cnt", 64'(ovf_count), 64'(255));
        chk("sat_sticky", 64'(ovf_sticky), 64'(1));
        send(3'b110, 32'h0, 32'h1, 1'b1, 4'd9);
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) break;
            step();
        end
        chk("clr_race_valid", 64'(rsp_valid), 64'(1));
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        chk("clr_race_cnt", 64'(ovf_count), 64'(0));
        chk("clr_race_sticky", 64'(ovf_sticky), 64'(0));

        for (int i = 0; i < 600; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_op     = 3'($urandom_range(0, 7));
            req_a      = rnd32();
            req_b      = rnd32();
            req_unsig  = 1'($urandom_range(0, 1));
            req_tag    = 4'($urandom_range(0, 15));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 63) == 0);
            step();
        end
        clr_sticky = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_alu_exec_unit
`default_nettype wire
